// File: rtl/score_counter.sv
// Score counter: edge-detects the asynchronous score tick and accumulates a packed-BCD score,
// with game start/stop tracking. Define SCORE_HISCORE_EN to build the high-score compare/commit.

module bcd_digit_inc (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (d == 4'd9) begin
        q    = 4'd0;
        cout = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end
  end
endmodule

module score_counter #(
  parameter int DIGITS          = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int MILESTONE_DIGIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gameon,
  input  logic                score_tick,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hiscore_bcd,
  output logic                milestone,
  output logic                saturated,
  output logic                new_hiscore,
  output logic [1:0]          state
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_prev;
  logic                   tick_q;
  logic                   gameon_q;
  logic                   tick_rise, go_rise, go_fall, inc_en;
  logic [DIGITS:0]        carry;
  logic [4*DIGITS-1:0]    score_inc;

  assign tick_rise = sync_ff[SYNC_STAGES-1] & ~sync_prev;
  assign go_rise   = gameon & ~gameon_q;
  assign go_fall   = ~gameon & gameon_q;

  // Edge pulse is registered once more so an update lands SYNC_STAGES+1 clocks after sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff   <= '0;
      sync_prev <= 1'b0;
      tick_q    <= 1'b0;
      gameon_q  <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) sync_ff[i] <= sync_ff[i-1];
      sync_ff[0] <= score_tick;
      sync_prev  <= sync_ff[SYNC_STAGES-1];
      tick_q     <= tick_rise;
      gameon_q   <= gameon;
    end
  end

  // Ripple +1 through the digits; a carry out of the top digit means every digit is 9.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_inc u_inc (
      .d    (score_bcd[4*g +: 4]),
      .cin  (carry[g]),
      .q    (score_inc[4*g +: 4]),
      .cout (carry[g+1])
    );
  end
  assign saturated = carry[DIGITS];

  assign inc_en = (state == RUN) & tick_q & ~go_rise & ~go_fall & ~saturated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      score_bcd <= '0;
      milestone <= 1'b0;
    end else begin
      milestone <= 1'b0;
      case (state)
        IDLE, OVER: if (go_rise) begin
          state     <= RUN;
          score_bcd <= '0;
        end
        RUN: if (go_fall) begin
          state <= OVER;
        end else if (inc_en) begin
          score_bcd <= score_inc;
          milestone <= (score_inc[4*MILESTONE_DIGIT-1:0] == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  logic commit;
  assign commit = (state == RUN) & go_fall;

  // Packed BCD with valid digits orders identically to its unsigned binary value,
  // so the digit-wise MSB-first magnitude compare is a plain vector compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_bcd <= '0;
      new_hiscore <= 1'b0;
    end else begin
      new_hiscore <= 1'b0;
      if (commit && (score_bcd > hiscore_bcd)) begin
        hiscore_bcd <= score_bcd;
        new_hiscore <= 1'b1;
      end
    end
  end
`else
  assign hiscore_bcd = '0;
  assign new_hiscore = 1'b0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: default 5-digit instance plus a 2-digit instance for saturation.

module tb_score_counter;
`ifdef SCORE_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, gameon, gameon2, score_tick;
  logic [19:0] score_bcd, hiscore_bcd;
  logic        milestone, saturated, new_hiscore;
  logic [1:0]  state;
  logic [7:0]  score2, hiscore2;
  logic        ms2, sat2, nh2;
  logic [1:0]  state2;

  int checks = 0;
  int failures = 0;
  int ms_cnt = 0, ms_long = 0, ms2_cnt = 0, nh_cnt = 0;
  logic ms_prev = 1'b0;

  always #5 clk = ~clk;

  score_counter #(.DIGITS(5), .SYNC_STAGES(2), .MILESTONE_DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .gameon(gameon), .score_tick(score_tick),
    .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd), .milestone(milestone),
    .saturated(saturated), .new_hiscore(new_hiscore), .state(state)
  );

  score_counter #(.DIGITS(2), .SYNC_STAGES(2), .MILESTONE_DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .gameon(gameon2), .score_tick(score_tick),
    .score_bcd(score2), .hiscore_bcd(hiscore2), .milestone(ms2),
    .saturated(sat2), .new_hiscore(nh2), .state(state2)
  );

  always @(negedge clk) begin
    if (milestone) ms_cnt++;
    if (milestone && ms_prev) ms_long++;
    ms_prev = milestone;
    if (ms2) ms2_cnt++;
    if (new_hiscore) nh_cnt++;
  end

  task automatic tick_pulse();
    score_tick = 1'b1;
    repeat (3) @(negedge clk);
    score_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_pulse();
  endtask

  task automatic play_game(input int n);
    gameon = 1'b1;
    repeat (2) @(negedge clk);
    ticks(n);
    gameon = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gameon = 1'b0; gameon2 = 1'b0; score_tick = 1'b0;
    #1;
    checks++; if (score_bcd !== 20'h0) begin failures++; $display("FAIL reset_score got=%h exp=00000", score_bcd); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({milestone, saturated, new_hiscore} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {milestone, saturated, new_hiscore}); end
    checks++; if (hiscore_bcd !== 20'h0) begin failures++; $display("FAIL reset_hiscore got=%h exp=00000", hiscore_bcd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      tick_pulse();
      checks++; if ({state, score_bcd} !== 22'h0) begin failures++; $display("FAIL idle_tick%0d got state=%0d score=%h exp state=0 score=00000", i, state, score_bcd); end
    end
  endtask

  task automatic test_count();
    int lat;
    gameon = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL run_state got=%0d exp=1", state); end
    for (int t = 1; t <= 3; t++) begin
      lat = 0;
      score_tick = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (lat == 0 && score_bcd !== 20'(t - 1)) lat = i;
      end
      score_tick = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (lat != 4) begin failures++; $display("FAIL tick_latency%0d got=%0d exp=4", t, lat); end
      checks++; if (score_bcd !== 20'(t)) begin failures++; $display("FAIL count%0d got=%h exp=%05h", t, score_bcd, t); end
    end
  endtask

  task automatic test_milestone();
    int ms0, nh0;
    ms0 = ms_cnt;
    nh0 = nh_cnt;
    ticks(96);
    checks++; if (score_bcd !== 20'h00099) begin failures++; $display("FAIL count99 got=%h exp=00099", score_bcd); end
    checks++; if (ms_cnt != ms0) begin failures++; $display("FAIL no_ms_below100 got=%0d exp=%0d", ms_cnt, ms0); end
    ticks(1);
    checks++; if (score_bcd !== 20'h00100) begin failures++; $display("FAIL count100 got=%h exp=00100", score_bcd); end
    checks++; if (ms_cnt != ms0 + 1) begin failures++; $display("FAIL ms_at100 got=%0d exp=%0d", ms_cnt, ms0 + 1); end
    checks++; if (ms_long != 0) begin failures++; $display("FAIL ms_width got=%0d exp=0", ms_long); end
    gameon = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL over_state got=%0d exp=2", state); end
    checks++; if (hiscore_bcd !== (HS_EN ? 20'h00100 : 20'h0)) begin failures++; $display("FAIL hiscore_100 got=%h exp=%h", hiscore_bcd, HS_EN ? 20'h00100 : 20'h0); end
    checks++; if (nh_cnt != nh0 + (HS_EN ? 1 : 0)) begin failures++; $display("FAIL nh_100 got=%0d exp=%0d", nh_cnt - nh0, HS_EN ? 1 : 0); end
    tick_pulse();
    checks++; if (score_bcd !== 20'h00100) begin failures++; $display("FAIL over_hold got=%h exp=00100", score_bcd); end
  endtask

  task automatic test_saturate();
    gameon2 = 1'b1;
    repeat (2) @(negedge clk);
    ticks(99);
    checks++; if ({sat2, score2} !== 9'h199) begin failures++; $display("FAIL sat_reach got sat=%b score=%h exp sat=1 score=99", sat2, score2); end
    ticks(3);
    checks++; if (score2 !== 8'h99) begin failures++; $display("FAIL sat_hold got=%h exp=99", score2); end
    checks++; if (ms2_cnt != 0) begin failures++; $display("FAIL sat_no_ms got=%0d exp=0", ms2_cnt); end
    checks++; if ({saturated, score_bcd} !== 21'h00100) begin failures++; $display("FAIL main_untouched got sat=%b score=%h exp sat=0 score=00100", saturated, score_bcd); end
    gameon2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hiscore();
    int nh0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({state, hiscore_bcd} !== 22'h0) begin failures++; $display("FAIL hs_reset got state=%0d hi=%h exp state=0 hi=00000", state, hiscore_bcd); end
    nh0 = nh_cnt;
    play_game(42);
    checks++; if (score_bcd !== 20'h00042) begin failures++; $display("FAIL g1_score got=%h exp=00042", score_bcd); end
    checks++; if (hiscore_bcd !== (HS_EN ? 20'h00042 : 20'h0)) begin failures++; $display("FAIL g1_hiscore got=%h exp=%h", hiscore_bcd, HS_EN ? 20'h00042 : 20'h0); end
    checks++; if (nh_cnt - nh0 != (HS_EN ? 1 : 0)) begin failures++; $display("FAIL g1_pulse got=%0d exp=%0d", nh_cnt - nh0, HS_EN ? 1 : 0); end
    nh0 = nh_cnt;
    play_game(42);
    checks++; if (hiscore_bcd !== (HS_EN ? 20'h00042 : 20'h0)) begin failures++; $display("FAIL g2_hiscore got=%h exp=%h", hiscore_bcd, HS_EN ? 20'h00042 : 20'h0); end
    checks++; if (nh_cnt != nh0) begin failures++; $display("FAIL g2_pulse got=%0d exp=0", nh_cnt - nh0); end
    nh0 = nh_cnt;
    play_game(57);
    checks++; if (hiscore_bcd !== (HS_EN ? 20'h00057 : 20'h0)) begin failures++; $display("FAIL g3_hiscore got=%h exp=%h", hiscore_bcd, HS_EN ? 20'h00057 : 20'h0); end
    checks++; if (nh_cnt - nh0 != (HS_EN ? 1 : 0)) begin failures++; $display("FAIL g3_pulse got=%0d exp=%0d", nh_cnt - nh0, HS_EN ? 1 : 0); end
  endtask

  task automatic test_coincident();
    score_tick = 1'b1;
    repeat (3) @(negedge clk);
    gameon = 1'b1;
    repeat (4) @(negedge clk);
    score_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({state, score_bcd} !== {2'd1, 20'h0}) begin failures++; $display("FAIL rise_tick got state=%0d score=%h exp state=1 score=00000", state, score_bcd); end
    ticks(5);
    score_tick = 1'b1;
    repeat (3) @(negedge clk);
    gameon = 1'b0;
    repeat (4) @(negedge clk);
    score_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({state, score_bcd} !== {2'd2, 20'h00005}) begin failures++; $display("FAIL fall_tick got state=%0d score=%h exp state=2 score=00005", state, score_bcd); end
    checks++; if (hiscore_bcd !== (HS_EN ? 20'h00057 : 20'h0)) begin failures++; $display("FAIL fall_hiscore got=%h exp=%h", hiscore_bcd, HS_EN ? 20'h00057 : 20'h0); end
  endtask

  task automatic test_reset_midgame();
    gameon = 1'b1;
    repeat (2) @(negedge clk);
    ticks(25);
    checks++; if (score_bcd !== 20'h00025) begin failures++; $display("FAIL mid_score got=%h exp=00025", score_bcd); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({state, score_bcd, hiscore_bcd, milestone, new_hiscore} !== 44'h0) begin failures++; $display("FAIL async_reset got state=%0d score=%h hi=%h exp all zero", state, score_bcd, hiscore_bcd); end
    gameon = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    checks++; if ({state, score_bcd} !== 22'h0) begin failures++; $display("FAIL post_reset_idle got state=%0d score=%h exp state=0 score=00000", state, score_bcd); end
    gameon = 1'b1;
    repeat (2) @(negedge clk);
    ticks(1);
    checks++; if ({state, score_bcd} !== {2'd1, 20'h00001}) begin failures++; $display("FAIL post_reset_run got state=%0d score=%h exp state=1 score=00001", state, score_bcd); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_milestone();
    test_saturate();
    test_hiscore();
    test_coincident();
    test_reset_midgame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
